// File: rtl/uart_tx_frame.sv
// 8E1 (or 8N1) serial transmitter with a registered TxD.
// One byte is accepted per frame; writes made while busy or disabled are dropped.
module uart_tx_frame #(
   parameter int BIT_CYCLES = 16,
   parameter bit PARITY_EN  = 1'b1
) (
   input  logic       clkdv,
   input  logic       reset,
   input  logic       Tx_EN,
   input  logic       Tx_WR,
   input  logic [7:0] Tx_DATA,
   output logic       TxD,
   output logic       Tx_BUSY,
   output logic       Tx_DONE
);

   localparam int CW = $clog2(BIT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t        state, state_d;
   logic [7:0]    shreg, shreg_d;
   logic          par, par_d;
   logic [2:0]    bit_cnt, bit_d;
   logic [CW-1:0] cyc, cyc_d;
   logic          txd_d, busy_d, done_d;
   logic          last;

   assign last = (cyc == LAST);

   always_comb begin
      state_d = state;
      shreg_d = shreg;
      par_d   = par;
      bit_d   = bit_cnt;
      cyc_d   = cyc;
      done_d  = 1'b0;
      unique case (state)
         IDLE: begin
            if (Tx_WR && Tx_EN) begin
               state_d = START;
               shreg_d = Tx_DATA;
               par_d   = ^Tx_DATA;
               bit_d   = '0;
               cyc_d   = '0;
            end
         end
         START: begin
            cyc_d = last ? '0 : cyc + CW'(1);
            if (last) state_d = DATA;
         end
         DATA: begin
            cyc_d = last ? '0 : cyc + CW'(1);
            if (last) begin
               shreg_d = shreg >> 1;
               bit_d   = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7)
                  state_d = PARITY_EN ? PARITY : STOP;
            end
         end
         PARITY: begin
            cyc_d = last ? '0 : cyc + CW'(1);
            if (last) state_d = STOP;
         end
         STOP: begin
            cyc_d = last ? '0 : cyc + CW'(1);
            if (last) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // TxD is derived from the next state so the pin changes on the same edge as the state
   always_comb begin
      txd_d = 1'b1;
      unique case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shreg_d[0];
         PARITY:  txd_d = par_d;
         default: txd_d = 1'b1;
      endcase
   end

   assign busy_d = (state_d != IDLE);

   always_ff @(posedge clkdv or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         shreg   <= '0;
         par     <= 1'b0;
         bit_cnt <= '0;
         cyc     <= '0;
         TxD     <= 1'b1;
         Tx_BUSY <= 1'b0;
         Tx_DONE <= 1'b0;
      end else begin
         state   <= state_d;
         shreg   <= shreg_d;
         par     <= par_d;
         bit_cnt <= bit_d;
         cyc     <= cyc_d;
         TxD     <= txd_d;
         Tx_BUSY <= busy_d;
         Tx_DONE <= done_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Randomized bench for uart_tx_frame; frames are predicted as bit lists
// built from the byte, then compared cycle by cycle on the serial line.
module tb_uart_tx_frame;

   localparam int BC = 4;

   logic       clkdv = 1'b0;
   logic       reset;
   logic       Tx_EN;
   logic       Tx_WR;
   logic [7:0] Tx_DATA;
   logic       TxD, Tx_BUSY, Tx_DONE;
   logic       txd_np, busy_np, done_np;

   int errors = 0;
   int checks = 0;

   always #5 clkdv = ~clkdv;

   uart_tx_frame #(.BIT_CYCLES(BC), .PARITY_EN(1'b1)) dut (
      .clkdv  (clkdv),
      .reset  (reset),
      .Tx_EN  (Tx_EN),
      .Tx_WR  (Tx_WR),
      .Tx_DATA(Tx_DATA),
      .TxD    (TxD),
      .Tx_BUSY(Tx_BUSY),
      .Tx_DONE(Tx_DONE)
   );

   uart_tx_frame #(.BIT_CYCLES(BC), .PARITY_EN(1'b0)) dut_np (
      .clkdv  (clkdv),
      .reset  (reset),
      .Tx_EN  (Tx_EN),
      .Tx_WR  (Tx_WR),
      .Tx_DATA(Tx_DATA),
      .TxD    (txd_np),
      .Tx_BUSY(busy_np),
      .Tx_DONE(done_np)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clkdv);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   // Write d, then follow the whole frame on the chosen instance.
   task automatic run_frame(input logic [7:0] d, input bit pe,
                            input int inj_at, input logic [7:0] inj_d,
                            input int drop_at);
      bit exp_q[$];
      int n;
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
      if (pe) exp_q.push_back(^d);
      exp_q.push_back(1'b1);
      n = exp_q.size() * BC;
      Tx_DATA = d;
      Tx_WR   = 1'b1;
      tick();
      Tx_WR   = 1'b0;
      Tx_DATA = 8'($urandom);
      for (int k = 0; k < n; k++) begin
         chk("txd", pe ? TxD : txd_np, exp_q[k / BC]);
         chk("busy", pe ? Tx_BUSY : busy_np, 1);
         chk("done_low", pe ? Tx_DONE : done_np, 0);
         if (k == inj_at) begin
            Tx_WR   = 1'b1;
            Tx_DATA = inj_d;
         end else begin
            Tx_WR = 1'b0;
         end
         if (k == drop_at) Tx_EN = 1'b0;
         tick();
      end
      Tx_WR = 1'b0;
      chk("busy_end", pe ? Tx_BUSY : busy_np, 0);
      chk("done_pulse", pe ? Tx_DONE : done_np, 1);
      chk("txd_mark", pe ? TxD : txd_np, 1);
   endtask

   task automatic expect_no_frame(input int n);
      for (int k = 0; k < n; k++) begin
         chk("idle_busy", Tx_BUSY, 0);
         chk("idle_txd", TxD, 1);
         chk("idle_done", Tx_DONE, 0);
         tick();
      end
   endtask

   initial begin
      reset   = 1'b1;
      Tx_EN   = 1'b1;
      Tx_WR   = 1'b0;
      Tx_DATA = 8'h00;
      idle(3);
      chk("rst_txd", TxD, 1);
      chk("rst_busy", Tx_BUSY, 0);
      chk("rst_done", Tx_DONE, 0);
      reset = 1'b0;
      expect_no_frame(20);

      run_frame(8'hA5, 1'b1, -1, 8'h00, -1);
      chk("done_once", Tx_DONE, 1);
      tick();
      chk("done_clear", Tx_DONE, 0);

      idle(8);
      run_frame(8'h07, 1'b1, -1, 8'h00, -1);
      idle(8);
      run_frame(8'h00, 1'b1, -1, 8'h00, -1);
      idle(8);
      run_frame(8'h07, 1'b0, -1, 8'h00, -1);
      idle(12);

      run_frame(8'h55, 1'b1, 10, 8'h3C, -1);
      run_frame(8'h3C, 1'b1, -1, 8'h00, -1);
      idle(8);

      Tx_EN   = 1'b0;
      Tx_DATA = 8'hFF;
      Tx_WR   = 1'b1;
      tick();
      Tx_WR = 1'b0;
      expect_no_frame(8);
      Tx_EN = 1'b1;
      idle(8);
      run_frame(8'h5A, 1'b1, -1, 8'h00, 20);
      Tx_DATA = 8'hC3;
      Tx_WR   = 1'b1;
      tick();
      Tx_WR = 1'b0;
      expect_no_frame(8);
      Tx_EN = 1'b1;
      idle(8);

      Tx_DATA = 8'h96;
      Tx_WR   = 1'b1;
      tick();
      Tx_WR = 1'b0;
      idle(17);
      chk("pre_rst_busy", Tx_BUSY, 1);
      reset = 1'b1;
      #1;
      chk("mid_rst_txd", TxD, 1);
      chk("mid_rst_busy", Tx_BUSY, 0);
      tick();
      reset = 1'b0;
      tick();
      run_frame(8'($urandom), 1'b1, -1, 8'h00, -1);

      for (int r = 0; r < 10; r++) begin
         run_frame(8'($urandom), 1'b1, -1, 8'h00, -1);
         idle($urandom_range(0, 3));
      end
      idle(12);
      for (int r = 0; r < 3; r++) begin
         run_frame(8'($urandom), 1'b0, -1, 8'h00, -1);
         idle(12);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
